// File: rtl/issue_scoreboard_pkg.sv
// Shared opcode encodings, instruction field positions and scoreboard entry type
// for the issue controller between the fetch and execute pipes.
package issue_scoreboard_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_MUL  = 3'b010,
    OP_ADDI = 3'b011
  } opcode_e;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned RS1_LSB = 3;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS2_LSB = 13;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  localparam int unsigned SB_ENTRY_W = $bits(sb_entry_t);

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic [4:0] rs2;
    logic       writes;
    logic       use_rs1;
    logic       use_rs2;
  } predecode_t;

  // ADDI reuses the Rs2 field as immediate bits, so it only reads Rs1.
  function automatic predecode_t predecode(input logic [31:0] ins);
    predecode_t p;
    p.op      = ins[OP_LSB +: 3];
    p.rs1     = ins[RS1_LSB +: 5];
    p.rd      = ins[RD_LSB +: 5];
    p.rs2     = ins[RS2_LSB +: 5];
    p.writes  = (p.op == OP_ADD) || (p.op == OP_MUL) || (p.op == OP_ADDI);
    p.use_rs1 = p.writes;
    p.use_rs2 = (p.op == OP_ADD) || (p.op == OP_MUL);
    return p;
  endfunction

endpackage

// File: rtl/issue_scoreboard_hazard_cmp.sv
// Combinational RAW check: compares source registers against every valid
// in-flight destination held in the flattened scoreboard vector.
module sb_hazard_cmp
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic                        use_rs2,
  input  logic [DEPTH*SB_ENTRY_W-1:0] sb_flat,
  output logic                        hazard
);

  sb_entry_t e;

  // Register 0 is never written, so it can never be a hazard source.
  always_comb begin
    hazard = 1'b0;
    e      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e = sb_flat[i*SB_ENTRY_W +: SB_ENTRY_W];
      if (e.v) begin
        if ((rs1 != 5'd0) && (e.rd == rs1))
          hazard = 1'b1;
        if (use_rs2 && (rs2 != 5'd0) && (e.rd == rs2))
          hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: holds back RAW-dependent instructions with NOP bubbles,
// tracks in-flight destinations and counts issued instructions and stalls.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            flush,
  input  logic [31:0]     ins,
  input  logic            ins_valid,
  output logic            ins_ready,
  output logic [31:0]     issue_ins,
  output logic            start,
  output logic            stall,
  output logic [CNTW-1:0] issued_cnt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int LAT   = $clog2(WIDTH) - 1;
  localparam int DEPTH = LAT + 1;

  predecode_t              pd;
  logic [4:0]              rs1_eff;
  logic                    hazard;
  sb_entry_t               new_entry;
  sb_entry_t [DEPTH-1:0]   sb;

  always_comb begin
    pd      = predecode(ins);
    // Non-reading opcodes present r0, which the comparator never flags.
    rs1_eff = pd.use_rs1 ? pd.rs1 : 5'd0;
  end

  sb_hazard_cmp #(
    .DEPTH (DEPTH)
  ) u_cmp (
    .rs1     (rs1_eff),
    .rs2     (pd.rs2),
    .use_rs2 (pd.use_rs2),
    .sb_flat (sb),
    .hazard  (hazard)
  );

  always_comb begin
    ins_ready    = rst & run & ~flush & ins_valid & ~hazard;
    stall        = rst & run & ~flush & ins_valid & hazard;
    start        = rst & run;
    new_entry.v  = ins_ready & pd.writes & (pd.rd != 5'd0);
    new_entry.rd = new_entry.v ? pd.rd : 5'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_ins  <= '0;
      sb         <= '0;
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else if (run) begin
      if (flush) begin
        issue_ins <= '0;
        sb        <= '0;
      end else begin
        issue_ins <= ins_ready ? ins : '0;
        sb        <= {sb[DEPTH-2:0], new_entry};
        if (ins_ready && (pd.op != OP_NOP) && (issued_cnt != '1))
          issued_cnt <= issued_cnt + CNTW'(1);
        if (stall && (stall_cnt != '1))
          stall_cnt <= stall_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized scoreboard bench for issue_scoreboard; expectations come from a
// per-register "ready at run-edge N" model, checked by a separate monitor.
module tb_issue_scoreboard;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;

  logic        rdy16, rdy4, st16, st4, stl16, stl4;
  logic [31:0] iss16, iss4;
  logic [15:0] ic16, sc16;
  logic [3:0]  ic4, sc4;

  issue_scoreboard #(.WIDTH(16), .CNTW(16)) dut16 (
    .clk(clk), .rst(rst), .run(run), .flush(flush), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(rdy16), .issue_ins(iss16), .start(st16), .stall(stl16),
    .issued_cnt(ic16), .stall_cnt(sc16)
  );

  issue_scoreboard #(.WIDTH(16), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .flush(flush), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(rdy4), .issue_ins(iss4), .start(st4), .stall(stl4),
    .issued_cnt(ic4), .stall_cnt(sc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iss;
    int unsigned ic;
    int unsigned sc;
  } exp_t;

  exp_t        expq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: run-edge counter and the first run-edge at which each register may be read.
  int unsigned k = 0;
  int unsigned ready_at[32];
  logic [31:0] m_iss = '0;
  int unsigned m_ic = 0;
  int unsigned m_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w        = '0;
    w[2:0]   = 3'(op);
    w[7:3]   = 5'(rs1);
    w[12:8]  = 5'(rd);
    w[17:13] = 5'(rs2);
    return w;
  endfunction

  task automatic step(input logic r, input logic rn, input logic fl,
                      input logic [31:0] i, input logic v);
    exp_t        e;
    bit          hz, rdy, stl, wr, r1, r2;
    logic [2:0]  op;
    logic [4:0]  s1, s2, d;
    int unsigned edge_idx;
    @(negedge clk);
    rst = r; run = rn; flush = fl; ins = i; ins_valid = v;
    #1;
    op = i[2:0]; s1 = i[7:3]; d = i[12:8]; s2 = i[17:13];
    wr = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    r1 = wr;
    r2 = (op == 3'd1) || (op == 3'd2);
    if (!r) begin
      chk("rst_ready", {31'b0, rdy16}, 32'd0);
      chk("rst_stall", {31'b0, stl16}, 32'd0);
      chk("rst_start", {31'b0, st16}, 32'd0);
      chk("rst_issue", iss16, 32'd0);
      chk("rst_icnt", {16'b0, ic16}, 32'd0);
      chk("rst_scnt", {28'b0, sc4}, 32'd0);
      k = 0; m_iss = '0; m_ic = 0; m_sc = 0;
      foreach (ready_at[j]) ready_at[j] = 0;
    end else begin
      edge_idx = k + 1;
      hz = 0;
      if (r1 && s1 != 0 && ready_at[s1] > edge_idx) hz = 1;
      if (r2 && s2 != 0 && ready_at[s2] > edge_idx) hz = 1;
      rdy = rn && !fl && v && !hz;
      stl = rn && !fl && v && hz;
      chk("ready16", {31'b0, rdy16}, {31'b0, rdy});
      chk("ready4", {31'b0, rdy4}, {31'b0, rdy});
      chk("stall16", {31'b0, stl16}, {31'b0, stl});
      chk("stall4", {31'b0, stl4}, {31'b0, stl});
      chk("start", {31'b0, st16}, {31'b0, rn});
      if (rn) begin
        if (fl) begin
          m_iss = '0;
          foreach (ready_at[j]) ready_at[j] = 0;
        end else begin
          if (rdy) begin
            m_iss = i;
            if (op != 3'd0) m_ic++;
            if (wr && d != 0) ready_at[d] = edge_idx + DEPTH + 1;
          end else begin
            m_iss = '0;
          end
          if (stl) m_sc++;
        end
        k = edge_idx;
      end
    end
    e.iss = m_iss; e.ic = m_ic; e.sc = m_sc;
    expq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("issue_ins16", iss16, e.iss);
      chk("issue_ins4", iss4, e.iss);
      chk("issued_cnt16", {16'b0, ic16}, sat(e.ic, 32'hFFFF));
      chk("stall_cnt16", {16'b0, sc16}, sat(e.sc, 32'hFFFF));
      chk("issued_cnt4", {28'b0, ic4}, sat(e.ic, 15));
      chk("stall_cnt4", {28'b0, sc4}, sat(e.sc, 15));
    end
  end

  initial begin
    logic [31:0] w;
    int unsigned sel;
    foreach (ready_at[j]) ready_at[j] = 0;

    // 1: reset mid-stall, then first instruction after release is accepted
    step(0, 0, 0, '0, 0);
    step(1, 1, 0, mk(1, 3, 1, 2), 1);
    step(1, 1, 0, mk(1, 5, 3, 4), 1);
    step(1, 1, 0, mk(1, 5, 3, 4), 1);
    step(0, 1, 0, mk(1, 5, 3, 4), 1);
    step(0, 1, 0, mk(1, 5, 3, 4), 1);
    step(1, 1, 0, mk(1, 4, 5, 6), 1);
    step(1, 1, 0, '0, 0);

    // 2: independent ADD then MUL back-to-back
    step(0, 0, 0, '0, 0);
    step(1, 1, 0, mk(1, 3, 1, 2), 1);
    step(1, 1, 0, mk(2, 6, 4, 5), 1);
    step(1, 1, 0, '0, 0);

    // 3: RAW dependent right after producer
    step(0, 0, 0, '0, 0);
    step(1, 1, 0, mk(1, 3, 1, 2), 1);
    repeat (5) step(1, 1, 0, mk(1, 5, 3, 4), 1);
    step(1, 1, 0, '0, 0);

    // 4: r0 never hazards; ADDI immediate bits do not alias Rs2
    step(1, 1, 0, mk(1, 0, 1, 2), 1);
    step(1, 1, 0, mk(1, 7, 0, 0), 1);
    step(1, 1, 0, mk(1, 9, 1, 2), 1);
    step(1, 1, 0, mk(3, 10, 1, 9), 1);
    step(1, 1, 0, '0, 0);

    // 5: freeze while hazarded, then flush, then accept
    repeat (6) step(1, 1, 0, '0, 0);
    step(1, 1, 0, mk(1, 11, 1, 2), 1);
    step(1, 1, 0, mk(1, 12, 11, 1), 1);
    repeat (3) step(1, 0, 0, mk(1, 12, 11, 1), 1);
    step(1, 1, 1, mk(1, 12, 11, 1), 1);
    step(1, 1, 0, mk(1, 12, 11, 1), 1);
    step(1, 1, 0, '0, 0);

    // 6: long dependent chain drives the narrow stall counter into saturation
    repeat (35) step(1, 1, 0, mk(1, 3, 3, 3), 1);
    step(1, 1, 0, '0, 0);

    // Random traffic with a small register pool to provoke hazards
    for (int n = 0; n < 800; n++) begin
      w = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 3) w[2:0] = 3'd1;
      else if (sel < 5) w[2:0] = 3'd2;
      else if (sel < 7) w[2:0] = 3'd3;
      else if (sel < 8) w[2:0] = 3'd0;
      else w[2:0] = 3'($urandom_range(4, 7));
      w[7:3]   = 5'($urandom_range(0, 7));
      w[12:8]  = 5'($urandom_range(0, 7));
      w[17:13] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0), w, ($urandom_range(0, 4) != 0));
    end

    step(1, 0, 0, '0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
